// File: rtl/ncl_sync_adder_bridge_if.sv
// Single-rail operand/result handshake bundle for ncl_sync_adder_bridge.
// The bridge takes the slave side; the requester takes the master side.
interface ncl_sync_adder_bridge_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );
endinterface

// File: rtl/ncl_sync_adder_bridge.sv
// Clocked DATA/NULL sequencer around a dual-rail NCL ripple adder.
// Define NCL_WATCHDOG_EN to build the per-phase timeout watchdog.
module ncl_sync_adder_bridge #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ncl_sync_adder_bridge_if.slave bus,
   output logic [2*WIDTH-1:0]   ncl_a,
   output logic [2*WIDTH-1:0]   ncl_b,
   output logic [1:0]           ncl_cin,
   input  logic [2*WIDTH-1:0]   ncl_soma,
   input  logic [1:0]           ncl_cout,
   output logic                 busy,
   output logic                 err
);
   localparam int RW = 2 * WIDTH + 2;

   typedef enum logic [1:0] {IDLE, DATA, NULLW, OUT} state_t;

   state_t          state;
   state_t          next;
   logic [RW-1:0]   sync_q [SYNC_STAGES];
   logic [RW-1:0]   rails;
   logic            data_done;
   logic            null_done;
   logic            illegal;
   logic [WIDTH:0]  dec;
   logic            load;
   logic            capture;
   logic            to_null;
   logic            wd_data;
   logic            wd_null;
   logic            abort;

   function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] v);
      for (int i = 0; i < WIDTH; i++) begin
         enc[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
      end
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= {ncl_cout, ncl_soma};
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign rails = sync_q[SYNC_STAGES-1];

   // An 11 pair counts as "has data" so the FSM keeps moving; T rail decodes.
   always_comb begin
      data_done = 1'b1;
      null_done = 1'b1;
      illegal   = 1'b0;
      dec       = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         if (rails[2*i +: 2] == 2'b00) data_done = 1'b0;
         if (rails[2*i +: 2] != 2'b00) null_done = 1'b0;
         if (rails[2*i +: 2] == 2'b11) illegal = 1'b1;
         dec[i] = rails[2*i+1];
      end
   end

`ifdef NCL_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;
   logic          hit;

   assign hit     = (cnt == CW'(TIMEOUT - 1));
   assign wd_data = (state == DATA) && hit;
   assign wd_null = (state == NULLW) && hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         abort <= 1'b0;
      end else begin
         if (next != state && (next == DATA || next == NULLW)) begin
            cnt <= '0;
         end else if (state == DATA || state == NULLW) begin
            cnt <= cnt + CW'(1);
         end
         if (wd_data) begin
            abort <= 1'b1;
         end else if (state == IDLE) begin
            abort <= 1'b0;
         end
      end
   end
`else
   assign wd_data = 1'b0;
   assign wd_null = 1'b0;
   assign abort   = 1'b0;
`endif

   always_comb begin
      next    = state;
      load    = 1'b0;
      capture = 1'b0;
      to_null = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.in_valid && bus.in_ready) begin
               next = DATA;
               load = 1'b1;
            end
         end
         DATA: begin
            if (wd_data) begin
               next    = NULLW;
               to_null = 1'b1;
            end else if (data_done) begin
               next    = NULLW;
               capture = 1'b1;
               to_null = 1'b1;
            end
         end
         NULLW: begin
            if (wd_null) begin
               next = IDLE;
            end else if (null_done) begin
               next = abort ? IDLE : OUT;
            end
         end
         OUT: begin
            if (bus.out_ready) next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ncl_a         <= '0;
         ncl_b         <= '0;
         ncl_cin       <= '0;
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_sum   <= '0;
         bus.out_cout  <= 1'b0;
         busy          <= 1'b0;
         err           <= 1'b0;
      end else begin
         state         <= next;
         bus.in_ready  <= (next == IDLE);
         bus.out_valid <= (next == OUT);
         busy          <= (next != IDLE);
         if (load) begin
            ncl_a   <= enc(bus.in_a);
            ncl_b   <= enc(bus.in_b);
            ncl_cin <= bus.in_cin ? 2'b10 : 2'b01;
         end
         if (to_null) begin
            ncl_a   <= '0;
            ncl_b   <= '0;
            ncl_cin <= '0;
         end
         if (capture) begin
            bus.out_sum  <= dec[WIDTH-1:0];
            bus.out_cout <= dec[WIDTH];
         end
         if (illegal || wd_data || wd_null) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ncl_sync_adder_bridge.sv
// Bench for ncl_sync_adder_bridge with a delayed dual-rail adder model.
// Watchdog checks follow NCL_WATCHDOG_EN (TIMEOUT=16 here).
module tb_ncl_sync_adder_bridge;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [2*W-1:0] ncl_a;
   logic [2*W-1:0] ncl_b;
   logic [1:0]     ncl_cin;
   logic [2*W-1:0] soma;
   logic [1:0]     cout;
   logic           busy;
   logic           err;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   int dly        = 0;
   bit never_data = 1'b0;
   bit force11    = 1'b0;

   logic [W:0]     sb [$];
   logic [W:0]     msum;
   logic [2*W+1:0] tgt;
   logic [2*W+1:0] pipe [8];
   logic [2*W+1:0] ret;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ncl_sync_adder_bridge_if #(.WIDTH(W)) bus ();

   ncl_sync_adder_bridge #(
      .WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .ncl_a(ncl_a), .ncl_b(ncl_b), .ncl_cin(ncl_cin),
      .ncl_soma(soma), .ncl_cout(cout),
      .busy(busy), .err(err)
   );

   function automatic logic [W-1:0] m_dec(input logic [2*W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = v[2*i+1];
      return r;
   endfunction

   function automatic logic m_full(input logic [2*W-1:0] v);
      for (int i = 0; i < W; i++) if (v[2*i +: 2] == 2'b00) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [2*W-1:0] m_enc(input logic [W-1:0] v);
      logic [2*W-1:0] r;
      for (int i = 0; i < W; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   // behavioural dual-rail adder: DATA only when every input pair has data
   assign msum = {1'b0, m_dec(ncl_a)} + {1'b0, m_dec(ncl_b)} + {4'b0, ncl_cin[1]};

   always_comb begin
      tgt = '0;
      if (!never_data && m_full(ncl_a) && m_full(ncl_b) && ncl_cin != 2'b00) begin
         tgt = {msum[W] ? 2'b10 : 2'b01, m_enc(msum[W-1:0])};
         if (force11) tgt[1:0] = 2'b11;
      end
   end

   initial for (int i = 0; i < 8; i++) pipe[i] = '0;

   always @(posedge clk) begin
      pipe[0] <= tgt;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
   end

   always_comb begin
      ret = (dly == 0) ? tgt : pipe[dly-1];
   end
   assign {cout, soma} = ret;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      sb.delete();
      repeat (3) tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, output bit ok, output int acc);
      ok = 1'b0;
      acc = 0;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_cin = c;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         if (bus.in_ready) ok = 1'b1;
         tick();
      end
      acc = cyc;
      bus.in_valid = 1'b0;
      bus.in_a = W'($urandom);
      bus.in_b = W'($urandom);
      bus.in_cin = 1'($urandom);
   endtask

   task automatic take(input int hold, output logic [W:0] got, output bit ok);
      ok = 1'b0;
      got = '0;
      for (int k = 0; k < 100 && !ok; k++) begin
         if (bus.out_valid) ok = 1'b1;
         else tick();
      end
      repeat (hold) tick();
      got = {bus.out_cout, bus.out_sum};
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.in_cin = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      n_chk++;
      if ({ncl_a, ncl_b, ncl_cin} !== '0) begin
         n_fail++;
         $display("FAIL reset_ncl got=%h want=0", {ncl_a, ncl_b, ncl_cin});
      end
      n_chk++;
      if ({bus.in_ready, bus.out_valid, busy, err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctl got=%b want=0000",
                  {bus.in_ready, bus.out_valid, busy, err});
      end
      n_chk++;
      if ({bus.out_cout, bus.out_sum} !== '0) begin
         n_fail++;
         $display("FAIL reset_out got=%h want=0", {bus.out_cout, bus.out_sum});
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_chk++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready got=%b want=1", bus.in_ready);
      end
   endtask

   task automatic test_basic();
      bit ok;
      int acc;
      logic [W:0] got;
      logic [W:0] exp;
      dly = 3;
      sb.push_back(5'd8);
      send(4'd3, 4'd5, 1'b0, ok, acc);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL basic_accept got=timeout want=accept");
      end
      n_chk++;
      if (ncl_a !== 8'b01011010 || ncl_b !== 8'b01100110 || ncl_cin !== 2'b01) begin
         n_fail++;
         $display("FAIL basic_rails got=%b_%b_%b want=01011010_01100110_01",
                  ncl_a, ncl_b, ncl_cin);
      end
      n_chk++;
      if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_busy got=%b%b want=10", busy, bus.in_ready);
      end
      tick();
      n_chk++;
      if (ncl_a !== 8'b01011010) begin
         n_fail++;
         $display("FAIL basic_hold got=%b want=01011010", ncl_a);
      end
      take(0, got, ok);
      exp = sb.pop_front();
      n_chk++;
      if (!ok || got !== exp) begin
         n_fail++;
         $display("FAIL basic_result got=%h ok=%0d want=%h", got, ok, exp);
      end
   endtask

   task automatic test_carry();
      bit ok;
      int acc;
      logic [W:0] got;
      logic [W:0] exp;
      dly = 1;
      repeat (4) tick();
      sb.push_back(5'h11);
      send(4'hF, 4'h1, 1'b1, ok, acc);
      take(2, got, ok);
      exp = sb.pop_front();
      n_chk++;
      if (!ok || got !== exp) begin
         n_fail++;
         $display("FAIL carry_f11 got=%h ok=%0d want=%h", got, ok, exp);
      end
      sb.push_back(5'h00);
      send(4'h0, 4'h0, 1'b0, ok, acc);
      take(0, got, ok);
      exp = sb.pop_front();
      n_chk++;
      if (!ok || got !== exp) begin
         n_fail++;
         $display("FAIL carry_zero got=%h ok=%0d want=%h", got, ok, exp);
      end
   endtask

   task automatic test_latency();
      bit ok;
      int acc;
      int lat;
      logic [W:0] exp;
      dly = 0;
      repeat (4) tick();
      sb.push_back(5'd13);
      send(4'd6, 4'd7, 1'b0, ok, acc);
      while (!bus.out_valid && cyc - acc < 50) tick();
      lat = cyc - acc;
      n_chk++;
      if (lat != 6) begin
         n_fail++;
         $display("FAIL latency got=%0d want=6", lat);
      end
      exp = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
         n_chk++;
         if ({bus.out_cout, bus.out_sum} !== exp || bus.in_ready !== 1'b0
             || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_%0d got=%h rdy=%b vld=%b want=%h 0 1", k,
                     {bus.out_cout, bus.out_sum}, bus.in_ready, bus.out_valid, exp);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      n_chk++;
      if ({bus.out_valid, busy, bus.in_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL out_to_idle got=%b want=001",
                  {bus.out_valid, busy, bus.in_ready});
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int acc;
      logic [W:0] got;
      logic [W:0] exp;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic c;
      int bad = 0;
      for (int n = 0; n < 20; n++) begin
         repeat (5) tick();
         dly = $urandom_range(0, 4);
         a = W'($urandom);
         b = W'($urandom);
         c = 1'($urandom);
         sb.push_back({1'b0, a} + {1'b0, b} + {4'b0, c});
         send(a, b, c, ok, acc);
         take($urandom_range(0, 3), got, ok);
         exp = sb.pop_front();
         n_chk++;
         if (!ok || got !== exp) begin
            n_fail++;
            bad++;
            $display("FAIL b2b_%0d a=%h b=%h c=%b got=%h want=%h",
                     n, a, b, c, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int acc;
      dly = 5;
      repeat (4) tick();
      send(4'd9, 4'd2, 1'b1, ok, acc);
      tick();
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({ncl_a, ncl_b, ncl_cin} !== '0) begin
         n_fail++;
         $display("FAIL midreset_ncl got=%h want=0", {ncl_a, ncl_b, ncl_cin});
      end
      n_chk++;
      if ({bus.out_valid, err, bus.in_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL midreset_ctl got=%b want=000",
                  {bus.out_valid, err, bus.in_ready});
      end
      sb.delete();
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_chk++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_release got=%b want=1", bus.in_ready);
      end
      repeat (8) tick();
   endtask

   task automatic test_illegal();
      bit ok;
      int acc;
      logic [W:0] got;
      logic [W:0] exp;
      dly = 0;
      force11 = 1'b1;
      sb.push_back(5'd3);
      send(4'd2, 4'd0, 1'b0, ok, acc);
      take(0, got, ok);
      exp = sb.pop_front();
      n_chk++;
      if (!ok || got !== exp) begin
         n_fail++;
         $display("FAIL illegal_result got=%h ok=%0d want=%h", got, ok, exp);
      end
      n_chk++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL illegal_err got=%b want=1", err);
      end
      force11 = 1'b0;
      apply_reset();
      n_chk++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_err_clear got=%b want=0", err);
      end
   endtask

   task automatic test_watchdog();
      bit ok;
      int acc;
      bit seen = 1'b0;
      int err_at = -1;
      never_data = 1'b1;
      dly = 0;
      repeat (4) tick();
      send(4'd1, 4'd1, 1'b0, ok, acc);
`ifdef NCL_WATCHDOG_EN
      while (!err && cyc - acc < 40) begin
         if (bus.out_valid) seen = 1'b1;
         tick();
      end
      err_at = cyc - acc;
      n_chk++;
      if (err !== 1'b1 || err_at != 16) begin
         n_fail++;
         $display("FAIL wd_err got=%b@%0d want=1@16", err, err_at);
      end
      n_chk++;
      if ({ncl_a, ncl_b, ncl_cin} !== '0) begin
         n_fail++;
         $display("FAIL wd_null got=%h want=0", {ncl_a, ncl_b, ncl_cin});
      end
      while (busy && cyc - acc < 80) begin
         if (bus.out_valid) seen = 1'b1;
         tick();
      end
      n_chk++;
      if (busy !== 1'b0 || seen) begin
         n_fail++;
         $display("FAIL wd_abort busy=%b valid_seen=%0d want 0 0", busy, seen);
      end
`else
      for (int k = 0; k < 40; k++) begin
         if (bus.out_valid) seen = 1'b1;
         tick();
      end
      n_chk++;
      if (err !== 1'b0 || busy !== 1'b1 || seen) begin
         n_fail++;
         $display("FAIL nowd_wait err=%b busy=%b seen=%0d want 0 1 0",
                  err, busy, seen);
      end
      n_chk++;
      if (ncl_a !== 8'b01010110) begin
         n_fail++;
         $display("FAIL nowd_hold got=%b want=01010110", ncl_a);
      end
`endif
      never_data = 1'b0;
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_latency();
      test_back_to_back();
      test_reset_mid();
      test_illegal();
      test_watchdog();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
